// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b - bin, LSB first, one bit per clock.
// Ports: clk, rst_n, start, a, b, bin in; busy, done, diff, bout out.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_a0;
  logic             w_b0;
  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  assign w_a0       = r_a[0];
  assign w_b0       = r_b[0];
  assign w_d        = w_a0 ^ w_b0 ^ r_br;
  assign w_br_next  = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= bin;
            r_res   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_res <= w_res_next;
          r_br  <= w_br_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_diff  <= w_res_next;
            r_bout  <= w_br_next;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          // A start here chains straight into the next operation.
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= bin;
            r_res   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor.
// Cycle-level reference model plus literal directed cases and a random sweep.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int n_tests;
  int n_fail;
  int n_done_model;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted op keeps busy for W cycles, then
  // done pulses and the result is (a - b - bin) in W+1 bit arithmetic.
  int           m_left;
  logic         m_done;
  logic [W-1:0] m_diff;
  logic         m_bout;
  logic [W:0]   m_pend;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_diff = '0;
      m_bout = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_diff = m_pend[W-1:0];
        m_bout = m_pend[W];
        n_done_model++;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_pend = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        m_left = W;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_busy", {31'b0, busy}, {31'b0, (m_left > 0)});
      chk("m_done", {31'b0, done}, {31'b0, m_done});
      chk("m_diff", {24'b0, diff}, {24'b0, m_diff});
      chk("m_bout", {31'b0, bout}, {31'b0, m_bout});
      chk("excl", {31'b0, busy & done}, 32'd0);
    end
  end

  task automatic wait_done(input string name, output int nbusy);
    bit ok;
    nbusy = 0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic ibin,
                        input logic [W-1:0] ed, input logic eb);
    int nb;
    @(posedge clk);
    #1;
    start = 1'b1;
    a = ia;
    b = ib;
    bin = ibin;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    bin = $urandom;
    wait_done(name, nb);
    chk({name, "_busy_cyc"}, nb, W);
    chk({name, "_diff"}, {24'b0, diff}, {24'b0, ed});
    chk({name, "_bout"}, {31'b0, bout}, {31'b0, eb});
  endtask

  initial begin
    int nb;
    int npulse;
    n_tests = 0;
    n_fail = 0;
    n_done_model = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_diff", {24'b0, diff}, 32'd0);
    chk("rst_bout", {31'b0, bout}, 32'd0);
    rst_n = 1'b1;

    run_op("t5m3", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    run_op("t0m1", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run_op("t80m7f", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);

    // Back-to-back: start held through DONE.
    @(posedge clk);
    #1;
    start = 1'b1;
    a = 8'h00;
    b = 8'h00;
    bin = 1'b1;
    @(posedge clk);
    #1;
    a = 8'hFF;
    b = 8'hFF;
    bin = 1'b0;
    wait_done("b2b1", nb);
    chk("b2b1_diff", {24'b0, diff}, 32'hFF);
    chk("b2b1_bout", {31'b0, bout}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_noidle", {31'b0, busy}, 32'd1);
    wait_done("b2b2", nb);
    chk("b2b2_diff", {24'b0, diff}, 32'h00);
    chk("b2b2_bout", {31'b0, bout}, 32'd0);

    // Start during RUN is ignored; operand changes do not matter.
    @(posedge clk);
    #1;
    start = 1'b1;
    a = 8'h10;
    b = 8'h01;
    bin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    a = 8'hFF;
    b = 8'h00;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'h3C;
    wait_done("midrun", nb);
    chk("midrun_diff", {24'b0, diff}, 32'h0F);
    chk("midrun_bout", {31'b0, bout}, 32'd0);
    npulse = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) npulse++;
    end
    chk("midrun_onepulse", npulse, 0);

    // Asynchronous reset mid-run.
    @(posedge clk);
    #1;
    start = 1'b1;
    a = 8'h77;
    b = 8'h22;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_diff", {24'b0, diff}, 32'd0);
    chk("arst_bout", {31'b0, bout}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    npulse = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) npulse++;
    end
    chk("arst_nodone", npulse, 0);
    run_op("t9m4", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0);

    // Random sweep checked by the model every cycle.
    n_done_model = 0;
    for (int c = 0; c < 40000 && n_done_model < 1000; c++) begin
      @(posedge clk);
      #1;
      start = ($urandom_range(0, 3) != 0);
      a = $urandom;
      b = $urandom;
      bin = $urandom;
    end
    chk("sweep_count", (n_done_model >= 1000), 32'd1);
    start = 1'b0;
    repeat (12) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
